data_mem_ctrl: RTL

Load/store controller that drives the SOC's word-wide data memory (8-bit word address, 32-bit data, combinational read, write on rising `clk`) on behalf of the MIPS32 core. It accepts byte, halfword and word loads and stores at byte addresses. Loads are returned sign- or zero-extended. Sub-word stores are performed as a read-modify-write, because the memory has only a whole-word write strobe. It sits between the core's MEM stage and the data memory, and stalls the core via `busy` until `done`.

---
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Byte/half/word load-store controller for a word-wide data memory.
// Sub-word stores use read-modify-write since memory has one write strobe.
module data_mem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              bad;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_val;

    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    always_comb begin
        bad = 1'b0;
        unique case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = |addr[1:0];
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (bad)
                        state_nx = DONE;
                    else if (!we || size != 2'b10)
                        state_nx = READ;
                    else
                        state_nx = WRITE;
                end
            end
            READ:    state_nx = we_q ? WRITE : DONE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        byte_lane = mem_rdata[7:0];
        unique case (off_q)
            2'd0: byte_lane = mem_rdata[7:0];
            2'd1: byte_lane = mem_rdata[15:8];
            2'd2: byte_lane = mem_rdata[23:16];
            2'd3: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'b00:   load_val = {{24{sext_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{sext_q & half_lane[15]}}, half_lane};
            default: load_val = mem_rdata;
        endcase
    end

    // Merge: keep the word read back, overwrite only the addressed lane.
    always_comb begin
        mem_wdata = merge_q;
        unique case (size_q)
            2'b00: begin
                unique case (off_q)
                    2'd0: mem_wdata[7:0]   = wdata_q[7:0];
                    2'd1: mem_wdata[15:8]  = wdata_q[7:0];
                    2'd2: mem_wdata[23:16] = wdata_q[7:0];
                    2'd3: mem_wdata[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (off_q[1])
                    mem_wdata[31:16] = wdata_q[15:0];
                else
                    mem_wdata[15:0] = wdata_q[15:0];
            end
            default: mem_wdata = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                sext_q  <= sign_ext;
                off_q   <= addr[1:0];
                waddr_q <= addr[ADDR_W+1:2];
                wdata_q <= wdata;
                err_q   <= bad;
            end
            if (state == READ) begin
                if (we_q)
                    merge_q <= mem_rdata;
                else
                    rdata_q <= load_val;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = done & err_q;
    assign mem_read  = (state == READ);
    assign mem_write = (state == WRITE);
    assign mem_addr  = waddr_q;
    assign rdata     = rdata_q;

endmodule
